// File: rtl/rx_module.sv
// ---------------------------------------------------------------------------
// rx_module -- UART 8N1 receiver
//
// Synchronises an asynchronous serial line, detects the falling edge of a
// start bit, samples every bit at mid-period and checks the stop bit. A good
// frame updates Rx_Data and pulses Rx_Done_Sig for one cycle. A frame whose
// stop bit reads 0 pulses Rx_Err_Sig for one cycle and leaves Rx_Data alone.
//
// Parameters
//   BPS_DIV      CLK cycles per bit (default 50 MHz / 9600 baud), 4..65535
//   BPS_MID      counter value at which a bit is sampled
//
// Ports
//   CLK          system clock, rising edge
//   RST_n        asynchronous active-low reset
//   Rx_En_Sig    level enable; 0 idles the receiver or aborts a frame
//   Rx_Pin_In    asynchronous serial line, idles high
//   Rx_Data      last correctly framed byte, LSB received first
//   Rx_Done_Sig  one-cycle pulse, Rx_Data has just been updated
//   Rx_Err_Sig   one-cycle pulse, framing error (stop bit sampled 0)
// ---------------------------------------------------------------------------
module rx_module #(
  parameter int unsigned BPS_DIV = 5208,
  parameter int unsigned BPS_MID = BPS_DIV / 2
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic       Rx_En_Sig,
  input  logic       Rx_Pin_In,
  output logic [7:0] Rx_Data,
  output logic       Rx_Done_Sig,
  output logic       Rx_Err_Sig
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(BPS_DIV - 1);
  localparam logic [15:0] CNT_MID  = 16'(BPS_MID);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        s1_q, s1_d;
  logic        s2_q, s2_d;
  logic        s3_q, s3_d;

  logic        start_edge;
  logic        sample;
  logic        wrap;

  // s3 holds the previous synchronised value, so a 1 followed by a 0 is a
  // fresh falling edge; a line stuck low never looks like a new start.
  assign start_edge = s3_q & ~s2_q;
  assign sample     = (cnt_q == CNT_MID);
  assign wrap       = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    s1_d    = Rx_Pin_In;
    s2_d    = s1_q;
    s3_d    = s2_q;

    if (state_q != IDLE) begin
      cnt_d = wrap ? 16'd0 : cnt_q + 16'd1;
    end

    unique case (state_q)
      IDLE: begin
        cnt_d = 16'd0;
        idx_d = 3'd0;
        if (Rx_En_Sig && start_edge) begin
          state_d = START;
        end
      end

      // The start bit is validated at mid-bit; if it is still low we stay
      // here until the bit boundary so DATA starts with cnt aligned to the
      // beginning of data bit 0 and samples it at its middle.
      START: begin
        if (sample && s2_q) begin
          state_d = IDLE;
          cnt_d   = 16'd0;
        end else if (wrap) begin
          state_d = DATA;
          cnt_d   = 16'd0;
          idx_d   = 3'd0;
        end
      end

      DATA: begin
        if (sample) begin
          shift_d[idx_q] = s2_q;
        end
        if (wrap) begin
          if (idx_q == 3'd7) begin
            state_d = STOP;
            cnt_d   = 16'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end

      // Leaving at mid stop bit gives half a bit of slack to catch a
      // back-to-back start bit.
      STOP: begin
        if (sample) begin
          if (s2_q) begin
            data_d = shift_q;
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = IDLE;
          cnt_d   = 16'd0;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = 16'd0;
      end
    endcase

    // Dropping the enable abandons the frame silently.
    if (!Rx_En_Sig && (state_q != IDLE)) begin
      state_d = IDLE;
      cnt_d   = 16'd0;
      data_d  = data_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      s3_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
    end
  end

  assign Rx_Data     = data_q;
  assign Rx_Done_Sig = done_q;
  assign Rx_Err_Sig  = err_q;

endmodule

// File: tb/tb_rx_module.sv
// ---------------------------------------------------------------------------
// tb_rx_module -- directed bench for rx_module with BPS_DIV = 16
//
// A bit-level driver plays frames onto Rx_Pin_In; a monitor logs every done
// and error pulse with its cycle number, and the main sequence compares the
// log and the outputs with hand-computed values.
// ---------------------------------------------------------------------------
module tb_rx_module;

  localparam int DIV = 16;

  logic       CLK;
  logic       RST_n;
  logic       Rx_En_Sig;
  logic       Rx_Pin_In;
  logic [7:0] Rx_Data;
  logic       Rx_Done_Sig;
  logic       Rx_Err_Sig;

  int         cyc;
  int         total_checks;
  int         passed_checks;

  int         done_count;
  int         err_count;
  logic [7:0] rx_bytes [16];
  int         done_cyc [16];
  int         overlap_count;
  int         repeat_count;
  logic       prev_done;
  logic       prev_err;
  int         fall_cyc;

  rx_module #(
    .BPS_DIV(DIV)
  ) dut (
    .CLK        (CLK),
    .RST_n      (RST_n),
    .Rx_En_Sig  (Rx_En_Sig),
    .Rx_Pin_In  (Rx_Pin_In),
    .Rx_Data    (Rx_Data),
    .Rx_Done_Sig(Rx_Done_Sig),
    .Rx_Err_Sig (Rx_Err_Sig)
  );

  // 10 time-unit clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Free-running cycle number, advanced at every rising edge
  initial cyc = 0;
  always @(posedge CLK) cyc = cyc + 1;

  // Pulse monitor on the falling edge, away from the active edge
  initial begin
    done_count    = 0;
    err_count     = 0;
    overlap_count = 0;
    repeat_count  = 0;
    prev_done     = 1'b0;
    prev_err      = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rx_bytes[i] = 8'h00;
      done_cyc[i] = 0;
    end
  end

  always @(negedge CLK) begin
    if (Rx_Done_Sig === 1'b1) begin
      if (done_count < 16) begin
        rx_bytes[done_count] = Rx_Data;
        done_cyc[done_count] = cyc;
      end
      done_count = done_count + 1;
    end
    if (Rx_Err_Sig === 1'b1) err_count = err_count + 1;
    if (Rx_Done_Sig === 1'b1 && Rx_Err_Sig === 1'b1) overlap_count = overlap_count + 1;
    if ((Rx_Done_Sig === 1'b1 && prev_done) || (Rx_Err_Sig === 1'b1 && prev_err))
      repeat_count = repeat_count + 1;
    prev_done = (Rx_Done_Sig === 1'b1);
    prev_err  = (Rx_Err_Sig === 1'b1);
  end

  // One comparison: counts it, and reports tag/observed/expected on failure
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total_checks = total_checks + 1;
    assert (observed === expected) passed_checks = passed_checks + 1;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  // Hold the line at a level for n clock cycles; always returns #1 after a
  // rising edge
  task automatic driveLine(input logic level, input int n);
    Rx_Pin_In = level;
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // One 8N1 frame; drop_bit >= 0 lowers Rx_En_Sig halfway through that bit
  task automatic applyStimulus(input logic [7:0] value, input logic stop_bit,
                               input int drop_bit);
    fall_cyc = cyc;
    driveLine(1'b0, DIV);
    for (int b = 0; b < 8; b++) begin
      if (b == drop_bit) begin
        driveLine(value[b], DIV / 2);
        Rx_En_Sig = 1'b0;
        driveLine(value[b], DIV - DIV / 2);
      end else begin
        driveLine(value[b], DIV);
      end
    end
    driveLine(stop_bit, DIV);
  endtask

  initial begin
    int first_fall;
    int gap;
    int latency;

    total_checks  = 0;
    passed_checks = 0;
    RST_n     = 1'b0;
    Rx_En_Sig = 1'b1;
    Rx_Pin_In = 1'b1;

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("reset_data", 32'(Rx_Data), 32'h00);
    checkOutput("reset_done", 32'(Rx_Done_Sig), 32'h0);
    checkOutput("reset_err", 32'(Rx_Err_Sig), 32'h0);
    #3 RST_n = 1'b1;
    @(posedge CLK);
    #1;
    driveLine(1'b1, 5);

    // Back-to-back frames with no idle between stop and next start
    first_fall = cyc;
    applyStimulus(8'hA5, 1'b1, -1);
    applyStimulus(8'h5A, 1'b1, -1);
    driveLine(1'b1, 20);
    checkOutput("b2b_done_count", 32'(done_count), 32'd2);
    checkOutput("b2b_byte0", 32'(rx_bytes[0]), 32'hA5);
    checkOutput("b2b_byte1", 32'(rx_bytes[1]), 32'h5A);
    gap = done_cyc[1] - done_cyc[0];
    checkOutput("b2b_gap_in_159_161", 32'(gap >= 159 && gap <= 161), 32'd1);
    latency = done_cyc[0] - first_fall;
    checkOutput("latency_in_155_157", 32'(latency >= 155 && latency <= 157), 32'd1);
    checkOutput("b2b_err_count", 32'(err_count), 32'd0);
    checkOutput("b2b_rx_data", 32'(Rx_Data), 32'h5A);

    // Short low glitch is rejected, then a 00 frame is received
    driveLine(1'b0, 4);
    driveLine(1'b1, 40);
    checkOutput("glitch_done_count", 32'(done_count), 32'd2);
    checkOutput("glitch_err_count", 32'(err_count), 32'd0);
    applyStimulus(8'h00, 1'b1, -1);
    driveLine(1'b1, 20);
    checkOutput("after_glitch_done_count", 32'(done_count), 32'd3);
    checkOutput("after_glitch_byte", 32'(rx_bytes[2]), 32'h00);

    // Framing error followed by a stuck-low line, then recovery
    applyStimulus(8'hFF, 1'b0, -1);
    driveLine(1'b0, 40);
    checkOutput("ferr_err_count", 32'(err_count), 32'd1);
    checkOutput("ferr_done_count", 32'(done_count), 32'd3);
    checkOutput("ferr_rx_data_kept", 32'(Rx_Data), 32'h00);
    driveLine(1'b1, 20);
    checkOutput("stuck_low_no_restart", 32'(done_count + err_count), 32'd4);
    applyStimulus(8'h81, 1'b1, -1);
    driveLine(1'b1, 20);
    checkOutput("recover_done_count", 32'(done_count), 32'd4);
    checkOutput("recover_byte", 32'(rx_bytes[3]), 32'h81);
    checkOutput("recover_err_count", 32'(err_count), 32'd1);

    // Enable dropped during data bit 3 of 3C, then C3 with enable back on
    applyStimulus(8'h3C, 1'b1, 3);
    driveLine(1'b1, 20);
    checkOutput("abort_done_count", 32'(done_count), 32'd4);
    checkOutput("abort_err_count", 32'(err_count), 32'd1);
    checkOutput("abort_rx_data_kept", 32'(Rx_Data), 32'h81);
    Rx_En_Sig = 1'b1;
    driveLine(1'b1, 10);
    applyStimulus(8'hC3, 1'b1, -1);
    driveLine(1'b1, 20);
    checkOutput("reenable_done_count", 32'(done_count), 32'd5);
    checkOutput("reenable_byte", 32'(rx_bytes[4]), 32'hC3);

    // Asynchronous reset in the middle of a frame
    driveLine(1'b0, DIV);
    driveLine(1'b1, DIV);
    driveLine(1'b0, DIV);
    driveLine(1'b1, DIV / 2);
    #3 RST_n = 1'b0;
    #1;
    checkOutput("midreset_data", 32'(Rx_Data), 32'h00);
    checkOutput("midreset_done", 32'(Rx_Done_Sig), 32'h0);
    checkOutput("midreset_err", 32'(Rx_Err_Sig), 32'h0);
    @(posedge CLK);
    @(posedge CLK);
    #3 RST_n = 1'b1;
    @(posedge CLK);
    #1;
    driveLine(1'b1, 30);
    checkOutput("midreset_no_pulse", 32'(done_count + err_count), 32'd6);
    applyStimulus(8'h7E, 1'b1, -1);
    driveLine(1'b1, 20);
    checkOutput("post_reset_done_count", 32'(done_count), 32'd6);
    checkOutput("post_reset_byte", 32'(rx_bytes[5]), 32'h7E);
    checkOutput("post_reset_rx_data", 32'(Rx_Data), 32'h7E);
    checkOutput("final_err_count", 32'(err_count), 32'd1);

    // Pulse shape over the whole run
    checkOutput("done_err_overlap", 32'(overlap_count), 32'd0);
    checkOutput("pulse_longer_than_1", 32'(repeat_count), 32'd0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
